// File: rtl/swd_spi_bridge.sv
// swd_spi_bridge: steers a 48-slot SPI bit stream onto a 2-wire SWD port.
// The host MCU formats the whole SWD transaction. This block only does three things:
// it decides swdio direction per slot, gates swclk, and captures the target's bits.
// Optional build macro SWD_ACK_ABORT_EN: when defined, a non-OK ACK ends the frame after slot 13.
module swd_spi_bridge #(
  parameter int   FRAME_BITS = 48,
  parameter logic SWCLK_IDLE = 1'b0
) (
  input  logic sck,
  input  logic rst_n,
  input  logic mosi,
  output logic miso,
  input  logic rnw,
  output logic swclk,
  inout  wire  swdio
);

  localparam logic [5:0] LAST_SLOT = 6'(FRAME_BITS - 1);
  localparam logic [5:0] END_SLOT  = 6'(FRAME_BITS);

  logic [5:0] bit_idx_q, bit_idx_d;
  logic       done_q, done_d;
  logic       miso_q, miso_d;
  logic       drive_dir;
  logic       drive_en;
`ifdef SWD_ACK_ABORT_EN
  logic [1:0] ack_q, ack_d;
`endif

  // Direction decode: host drives request slots always, and data/parity slots on writes.
  always_comb begin
    drive_dir = 1'b0;
    if (bit_idx_q <= 6'd9) begin
      drive_dir = 1'b1;
    end else if (!rnw && (bit_idx_q >= 6'd15) && (bit_idx_q <= LAST_SLOT)) begin
      drive_dir = 1'b1;
    end
  end

  assign drive_en = rst_n && !done_q && drive_dir;
  assign swdio    = drive_en ? mosi : 1'bz;

  // done only changes on the falling edge of sck, so gating with it cannot cut a high pulse.
  assign swclk = (rst_n && !done_q) ? sck : SWCLK_IDLE;
  assign miso  = miso_q;

  // Next-state: advance the slot counter, capture the bus, end the frame at 48 (or on a bad ACK).
  always_comb begin
    bit_idx_d = bit_idx_q;
    done_d    = done_q;
    miso_d    = miso_q;
`ifdef SWD_ACK_ABORT_EN
    ack_d     = ack_q;
`endif
    if (!done_q) begin
      miso_d = swdio;
      if (bit_idx_q == LAST_SLOT) begin
        bit_idx_d = END_SLOT;
        done_d    = 1'b1;
      end else begin
        bit_idx_d = bit_idx_q + 6'd1;
      end
`ifdef SWD_ACK_ABORT_EN
      if (bit_idx_q == 6'd11) ack_d[0] = swdio;
      if (bit_idx_q == 6'd12) ack_d[1] = swdio;
      // OK is 1,0,0 LSB first; anything else stops the frame with bit_idx parked at 14.
      if ((bit_idx_q == 6'd13) && ({swdio, ack_q} != 3'b001)) begin
        done_d = 1'b1;
      end
`endif
    end
  end

  // Slot state advances on the falling edge, after the target has sampled at the rising edge.
  always_ff @(negedge sck or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx_q <= 6'd0;
      done_q    <= 1'b0;
      miso_q    <= 1'b0;
`ifdef SWD_ACK_ABORT_EN
      ack_q     <= 2'b00;
`endif
    end else begin
      bit_idx_q <= bit_idx_d;
      done_q    <= done_d;
      miso_q    <= miso_d;
`ifdef SWD_ACK_ABORT_EN
      ack_q     <= ack_d;
`endif
    end
  end

endmodule

// File: tb/tb_swd_spi_bridge.sv
// Directed bench for swd_spi_bridge. swdio has a pull-up, so a released bus reads 1.
// The bench holds mosi at 0 in every slot where the DUT must release the bus.
// If the DUT drives one of those slots, the bus therefore reads 0.
module tb_swd_spi_bridge;

  logic sck, rst_n, mosi, rnw;
  logic miso, swclk;
  logic tgt_en, tgt_val;
  wire  swdio;

  int n_cmp = 0;
  int n_err = 0;

  pullup (swdio);
  assign swdio = tgt_en ? tgt_val : 1'bz;

  swd_spi_bridge #(.FRAME_BITS(48), .SWCLK_IDLE(1'b0)) dut (
    .sck   (sck),
    .rst_n (rst_n),
    .mosi  (mosi),
    .miso  (miso),
    .rnw   (rnw),
    .swclk (swclk),
    .swdio (swdio)
  );

  task automatic check(input string tag, input int slot, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s slot=%0d observed=%b expected=%b", tag, slot, obs, exp);
    end
  endtask

  // Set inputs while sck is low, raise sck, and leave time to sample after the edge.
  task automatic rise(input logic m, input logic te, input logic tv);
    mosi = m; tgt_en = te; tgt_val = tv;
    #4 sck = 1'b1;
    #1;
  endtask

  task automatic fall();
    #4 sck = 1'b0;
    #1;
  endtask

  task automatic rearm();
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    #2;
  endtask

  initial begin
    logic [47:0] w, r;
    logic [7:0]  req;
    logic [31:0] data;
    logic [2:0]  ack;
    logic        te, tv, ex;

    sck = 1'b0; rst_n = 1'b0; mosi = 1'b0; rnw = 1'b0; tgt_en = 1'b0; tgt_val = 1'b0;

    // 1. Held in reset while sck toggles.
    for (int i = 0; i < 3; i++) begin
      rise(1'b0, 1'b0, 1'b0);
      check("rst_swclk", i, swclk, 1'b0);
      check("rst_swdio", i, swdio, 1'b1);
      check("rst_miso", i, miso, 1'b0);
      fall();
    end

    // 2. Write frame with OK ACK.
    req = 8'hA1; data = 32'hCAFEBABE; ack = 3'b001;
    w = '0; w[9:2] = req; w[46:15] = data; w[47] = ^data;
    rnw = 1'b0;
    rearm();
    for (int n = 0; n < 48; n++) begin
      te = (n >= 11 && n <= 13);
      tv = te ? ack[n-11] : 1'b0;
      rise(w[n], te, tv);
      if (n >= 10 && n <= 14) ex = te ? tv : 1'b1;
      else ex = w[n];
      check("wr_swdio", n, swdio, ex);
      check("wr_swclk", n, swclk, 1'b1);
      fall();
      if (te) check("wr_ack_miso", n, miso, tv);
    end

    // 3. Read frame: DUT releases the bus from slot 10 onwards.
    req = 8'hA5; data = 32'h12345678;
    r = '0; r[9:2] = req;
    rnw = 1'b1;
    rearm();
    for (int n = 0; n < 48; n++) begin
      te = (n >= 11 && n <= 46);
      if (n >= 11 && n <= 13) tv = ack[n-11];
      else if (n >= 14 && n <= 45) tv = data[n-14];
      else if (n == 46) tv = ^data;
      else tv = 1'b0;
      rise(r[n], te, tv);
      ex = (n <= 9) ? r[n] : (te ? tv : 1'b1);
      check("rd_swdio", n, swdio, ex);
      check("rd_swclk", n, swclk, 1'b1);
      fall();
      check("rd_miso", n, miso, ex);
    end

    // 4. Frame complete: swclk idle, bus released, miso frozen at slot 47's released value.
    rise(1'b0, 1'b0, 1'b0);
    check("done_swclk", 48, swclk, 1'b0);
    check("done_swdio", 48, swdio, 1'b1);
    fall();
    rise(1'b0, 1'b1, 1'b0);
    check("done_swclk", 49, swclk, 1'b0);
    fall();
    check("done_miso_hold", 49, miso, 1'b1);
    tgt_en = 1'b0;

    // 5. Reset in slot 20 of a write, then a fresh frame.
    req = 8'h3C; data = 32'h0F0F5AA5;
    w = '0; w[9:2] = req; w[46:15] = data; w[47] = ^data;
    rnw = 1'b0;
    rearm();
    for (int n = 0; n < 20; n++) begin
      rise(w[n], 1'b0, 1'b0);
      fall();
    end
    rise(w[20], 1'b0, 1'b0);
    check("mid_swdio", 20, swdio, w[20]);
    mosi = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_swclk", 20, swclk, 1'b0);
    check("mid_rst_swdio", 20, swdio, 1'b1);
    check("mid_rst_miso", 20, miso, 1'b0);
    fall();
    rst_n = 1'b1;
    #2;
    req = 8'hA1;
    w = '0; w[9:2] = req;
    for (int n = 0; n < 10; n++) begin
      rise(w[n], 1'b0, 1'b0);
      check("restart_swdio", n, swdio, w[n]);
      check("restart_swclk", n, swclk, 1'b1);
      fall();
    end

    // 6. Write frame answered with WAIT (0,1,0).
    data = 32'hCAFEBABE; ack = 3'b010;
    w = '0; w[9:2] = req; w[46:15] = data; w[47] = ^data;
    rearm();
    for (int n = 0; n < 14; n++) begin
      te = (n >= 11 && n <= 13);
      tv = te ? ack[n-11] : 1'b0;
      rise(w[n], te, tv);
      check("wait_swclk", n, swclk, 1'b1);
      fall();
      if (te) check("wait_ack_miso", n, miso, tv);
    end
    for (int n = 14; n < 48; n++) begin
`ifdef SWD_ACK_ABORT_EN
      rise(1'b0, 1'b0, 1'b0);
      check("abort_swclk", n, swclk, 1'b0);
      check("abort_swdio", n, swdio, 1'b1);
`else
      rise(w[n], 1'b0, 1'b0);
      check("wait_run_swclk", n, swclk, 1'b1);
      check("wait_run_swdio", n, swdio, (n == 14) ? 1'b1 : w[n]);
`endif
      fall();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
